if_fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I pipeline; feeds the decode stage, where the immediate generator and register file consume id_instr.
- Holds the fetch PC and issues one request at a time to instruction memory over a req/ack handshake.
- Absorbs decode stalls with a one-entry skid buffer.
- Handles branch/jump redirects by flushing to NOP and discarding any in-flight response.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/if_fetch_stage_if.sv | 24 ++
 rtl/fetch_skid_buf.sv | 35 +++
 rtl/if_fetch_stage.sv | 121 ++++++++++++
 tb/tb_if_fetch_stage.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared RV32I pipeline types: word width, instruction/address words, fetch FSM states.
package pipe_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [XLEN-1:0] instr_t;
    typedef logic [XLEN-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_e;
endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: instruction memory handshake, EX redirect and the IF/ID outputs.
interface if_fetch_stage_if;
    import pipe_pkg::*;

    logic   imem_req;
    addr_t  imem_addr;
    logic   imem_ack;
    instr_t imem_rdata;
    logic   redirect;
    addr_t  redirect_pc;
    logic   id_stall;
    logic   id_valid;
    instr_t id_instr;
    addr_t  id_pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, id_stall
    );
    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, id_stall
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer catching a fetched word while decode is stalled.
module fetch_skid_buf import pipe_pkg::*; (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_load,
    input  logic   i_unload,
    input  logic   i_clear,
    input  instr_t i_instr,
    input  addr_t  i_pc,
    output logic   o_valid,
    output instr_t o_instr,
    output addr_t  o_pc
);
    logic   r_valid;
    instr_t r_instr;
    addr_t  r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
        end else if (i_clear || i_unload) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction fetch + IF/ID register: one outstanding imem request,
// skid buffer for decode stalls, redirect flush that discards in-flight data.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst,
    if_fetch_stage_if.master bus
);
    import pipe_pkg::*;

    fetch_state_e r_state;
    addr_t        r_fetch_pc;
    addr_t        r_target;
    logic         r_id_valid;
    instr_t       r_id_instr;
    addr_t        r_id_pc;

    logic   w_req, w_ack, w_slot_free;
    logic   w_skid_load, w_skid_unload, w_skid_valid;
    instr_t w_skid_instr;
    addr_t  w_skid_pc;
    addr_t  w_redir_pc;

    assign w_req       = (r_state == ST_FETCH) || (r_state == ST_DROP);
    assign w_ack       = bus.imem_ack && w_req;
    assign w_slot_free = !r_id_valid || !bus.id_stall;
    assign w_redir_pc  = bus.redirect_pc & ~32'h3;

    assign w_skid_load   = (r_state == ST_FETCH) && w_ack && !w_slot_free && !bus.redirect;
    assign w_skid_unload = (r_state == ST_FULL) && !bus.id_stall && !bus.redirect;

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (bus.redirect),
        .i_instr  (bus.imem_rdata),
        .i_pc     (r_fetch_pc),
        .o_valid  (w_skid_valid),
        .o_instr  (w_skid_instr),
        .o_pc     (w_skid_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_target   <= '0;
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
            r_id_pc    <= '0;
        end else if (bus.redirect) begin
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
            unique case (r_state)
                ST_FETCH: begin
                    // An unacked request must keep its address, so park the target in DROP.
                    if (w_ack) r_fetch_pc <= w_redir_pc;
                    else begin
                        r_target <= w_redir_pc;
                        r_state  <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    r_target <= w_redir_pc;
                    if (w_ack) begin
                        r_fetch_pc <= w_redir_pc;
                        r_state    <= ST_FETCH;
                    end
                end
                default: begin
                    r_fetch_pc <= w_redir_pc;
                    r_state    <= ST_FETCH;
                end
            endcase
        end else begin
            unique case (r_state)
                ST_IDLE: r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (w_ack) begin
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                        if (w_slot_free) begin
                            r_id_valid <= 1'b1;
                            r_id_instr <= bus.imem_rdata;
                            r_id_pc    <= r_fetch_pc;
                        end else begin
                            r_state <= ST_FULL;
                        end
                    end else if (w_slot_free && !bus.id_stall) begin
                        r_id_valid <= 1'b0;
                        r_id_instr <= NOP_INSTR;
                    end
                end
                ST_FULL: begin
                    if (!bus.id_stall && w_skid_valid) begin
                        r_id_valid <= 1'b1;
                        r_id_instr <= w_skid_instr;
                        r_id_pc    <= w_skid_pc;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (w_ack) begin
                        r_fetch_pc <= r_target;
                        r_state    <= ST_FETCH;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.id_valid  = r_id_valid;
    assign bus.id_instr  = r_id_instr;
    assign bus.id_pc     = r_id_pc;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized + directed bench for if_fetch_stage against a queue-based behavioural model.
module tb_if_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    if_fetch_stage_if ifc ();

    if_fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: fetch pointer, "discard next response" flag with pending target,
    // a queue of words fetched but not yet handed to decode, and the IF/ID view.
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t        m_buf[$];
    logic [31:0] m_pc, m_tgt, m_idi, m_idp;
    bit          m_started, m_drop, m_idv;

    function automatic bit m_req();
        return m_started && (m_buf.size() == 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit ack_eff, free;
        logic [31:0] t;
        ent_t e;
        ack_eff = ifc.imem_ack && m_req();
        free    = !m_idv || !ifc.id_stall;
        t       = ifc.redirect_pc & ~32'h3;
        if (rst) begin
            m_pc = 32'h0; m_tgt = 32'h0; m_started = 0; m_drop = 0;
            m_buf.delete(); m_idv = 0; m_idi = NOP; m_idp = 32'h0;
        end else if (ifc.redirect) begin
            m_idv = 0; m_idi = NOP;
            if (!m_started) begin m_started = 1; m_pc = t; end
            else if (m_buf.size() != 0) begin m_buf.delete(); m_pc = t; end
            else if (m_drop) begin
                if (ack_eff) begin m_pc = t; m_drop = 0; end
                else m_tgt = t;
            end
            else if (ack_eff) m_pc = t;
            else begin m_drop = 1; m_tgt = t; end
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_buf.size() != 0) begin
            if (!ifc.id_stall) begin
                m_idv = 1; m_idi = m_buf[0].instr; m_idp = m_buf[0].pc;
                void'(m_buf.pop_front());
            end
        end else if (m_drop) begin
            if (ack_eff) begin m_pc = m_tgt; m_drop = 0; end
        end else if (ack_eff) begin
            if (free) begin m_idv = 1; m_idi = ifc.imem_rdata; m_idp = m_pc; end
            else begin e.instr = ifc.imem_rdata; e.pc = m_pc; m_buf.push_back(e); end
            m_pc = m_pc + 32'd4;
        end else if (free && !ifc.id_stall) begin
            m_idv = 0; m_idi = NOP;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req",  {31'b0, ifc.imem_req}, {31'b0, m_req()});
            chk("imem_addr", ifc.imem_addr, m_pc);
            chk("id_valid",  {31'b0, ifc.id_valid}, {31'b0, m_idv});
            chk("id_instr",  ifc.id_instr, m_idi);
            chk("id_pc",     ifc.id_pc, m_idp);
        end
    end

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic cyc(input bit ack, input bit redir, input logic [31:0] rpc, input bit stall);
        ifc.imem_ack    = ack;
        ifc.imem_rdata  = m_pc + 32'h100;
        ifc.redirect    = redir;
        ifc.redirect_pc = rpc;
        ifc.id_stall    = stall;
        step();
    endtask

    initial begin
        ifc.imem_ack = 0; ifc.imem_rdata = 0; ifc.redirect = 0;
        ifc.redirect_pc = 0; ifc.id_stall = 0;
        rst = 1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst = 0;
        chk_en = 1;
        chk("rst req",   {31'b0, ifc.imem_req}, 32'h0);
        chk("rst addr",  ifc.imem_addr, 32'h0);
        chk("rst valid", {31'b0, ifc.id_valid}, 32'h0);
        chk("rst instr", ifc.id_instr, 32'h0000_0013);
        chk("rst pc",    ifc.id_pc, 32'h0);

        // Streaming with an ack every cycle
        cyc(1, 0, 0, 0);
        chk("first req",  {31'b0, ifc.imem_req}, 32'h1);
        chk("first addr", ifc.imem_addr, 32'h0);
        for (int k = 0; k < 6; k++) begin
            cyc(1, 0, 0, 0);
            chk("stream valid", {31'b0, ifc.id_valid}, 32'h1);
            chk("stream pc",    ifc.id_pc, 32'h4 * k);
            chk("stream instr", ifc.id_instr, 32'h100 + 32'h4 * k);
        end

        // Stall for 3 cycles while an ack lands
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 1);
            chk("stall req", {31'b0, ifc.imem_req}, 32'h0);
            chk("stall hold pc", ifc.id_pc, 32'h14);
        end
        cyc(0, 0, 0, 0);
        chk("unskid pc",    ifc.id_pc, 32'h18);
        chk("unskid instr", ifc.id_instr, 32'h118);
        cyc(1, 0, 0, 0);
        chk("post skid pc", ifc.id_pc, 32'h1C);

        // Redirect while request to 0x10 pending
        rst = 1; cyc(0, 0, 0, 0); rst = 0;
        cyc(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0);
        cyc(0, 1, 32'h200, 0);
        chk("redir valid", {31'b0, ifc.id_valid}, 32'h0);
        chk("redir addr hold", ifc.imem_addr, 32'h10);
        cyc(0, 0, 0, 0);
        chk("drop addr hold", ifc.imem_addr, 32'h10);
        cyc(1, 0, 0, 0);
        chk("drop done addr", ifc.imem_addr, 32'h200);
        chk("drop no data",   {31'b0, ifc.id_valid}, 32'h0);
        cyc(1, 0, 0, 0);
        chk("target pc",    ifc.id_pc, 32'h200);
        chk("target instr", ifc.id_instr, 32'h300);

        // Redirect coinciding with ack, unaligned target
        cyc(1, 1, 32'h43, 0);
        chk("redir+ack addr",  ifc.imem_addr, 32'h40);
        chk("redir+ack valid", {31'b0, ifc.id_valid}, 32'h0);
        cyc(1, 0, 0, 0);
        chk("redir+ack pc", ifc.id_pc, 32'h40);

        // Two redirects during one pending request
        cyc(0, 1, 32'h80, 0);
        cyc(0, 1, 32'hC0, 0);
        chk("double addr hold", ifc.imem_addr, 32'h44);
        cyc(1, 0, 0, 0);
        chk("double addr", ifc.imem_addr, 32'hC0);
        cyc(1, 0, 0, 0);
        chk("double pc", ifc.id_pc, 32'hC0);

        // Address wrap
        cyc(1, 1, 32'hFFFF_FFFC, 0);
        cyc(1, 0, 0, 0);
        chk("wrap addr",  ifc.imem_addr, 32'h0);
        chk("wrap pc",    ifc.id_pc, 32'hFFFF_FFFC);
        chk("wrap instr", ifc.id_instr, 32'h0000_00FC);

        // Reset mid-request, then a late ack
        cyc(0, 0, 0, 0);
        rst = 1; cyc(0, 0, 0, 0); rst = 0;
        chk("midrst req",  {31'b0, ifc.imem_req}, 32'h0);
        chk("midrst addr", ifc.imem_addr, 32'h0);
        cyc(1, 0, 0, 0);
        chk("late ack valid", {31'b0, ifc.id_valid}, 32'h0);
        chk("restart req",    {31'b0, ifc.imem_req}, 32'h1);
        cyc(1, 0, 0, 0);
        chk("restart pc", ifc.id_pc, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst             = ($urandom_range(0, 99) == 0);
            ifc.imem_ack    = ($urandom_range(0, 99) < 60);
            ifc.imem_rdata  = $urandom;
            ifc.redirect    = ($urandom_range(0, 99) < 8);
            ifc.redirect_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFF);
            ifc.id_stall    = ($urandom_range(0, 99) < 30);
            step();
        end
        rst = 0;

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
